// File: rtl/io_seq_pkg.sv
// Shared state encoding, window constants and local register map for io_bus_sequencer.
package io_seq_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, HOLD} seq_state_e;

  localparam logic [3:0]  LOCAL_WIN = 4'hF;
  localparam logic [15:0] BAD_DATA  = 16'hDEAD;

  localparam logic [11:0] REG_IRQ_PENDING   = 12'h000;
  localparam logic [11:0] REG_IRQ_MASK      = 12'h002;
  localparam logic [11:0] REG_TIMEOUT_COUNT = 12'h004;

  localparam int TIMEOUT_PEND_BIT = 15;

  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/io_seq_irq_ctrl.sv
// Interrupt pending/mask registers, saturating timeout counter and registered io_irq.
module io_seq_irq_ctrl
  import io_seq_pkg::*;
#(
  parameter int NUM_SLAVES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SLAVES-1:0] s_irq,
  input  logic                  timeout_evt,
  input  logic                  wr_en,
  input  logic [11:0]           wr_offset,
  input  logic [1:0]            wr_be,
  input  logic [15:0]           wr_data,
  output logic [15:0]           pending,
  output logic [15:0]           mask,
  output logic [15:0]           timeout_count,
  output logic                  io_irq
);

  logic [15:0] set_vec;
  logic [15:0] clr_vec;
  logic [15:0] be_mask;

  always_comb begin
    set_vec = '0;
    set_vec[NUM_SLAVES-1:0] = s_irq;
    set_vec[TIMEOUT_PEND_BIT] = timeout_evt;
    be_mask = lane_mask(wr_be);
    clr_vec = (wr_en && wr_offset == REG_IRQ_PENDING) ? (wr_data & be_mask) : '0;
  end

  // Set is OR-ed after the W1C clear so a live interrupt survives a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending       <= '0;
      mask          <= '0;
      timeout_count <= '0;
      io_irq        <= 1'b0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      if (wr_en && wr_offset == REG_IRQ_MASK)
        mask <= (mask & ~be_mask) | (wr_data & be_mask);
      if (timeout_evt && timeout_count != 16'hFFFF)
        timeout_count <= timeout_count + 16'd1;
      io_irq <= |(pending & mask);
    end
  end

endmodule

// File: rtl/io_bus_sequencer.sv
// Bridge-side sequencer: decodes io_* transactions into slave windows or local registers.
// Define IO_SEQ_TIMEOUT_EN to force completion of slaves that never assert ready.
module io_bus_sequencer
  import io_seq_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_bus_enable,
  input  logic                     io_rw,
  input  logic [15:0]              io_address,
  input  logic [1:0]               io_byte_enable,
  input  logic [15:0]              io_write_data,
  output logic [15:0]              io_read_data,
  output logic                     io_acknowledge,
  output logic                     io_irq,
  output logic [NUM_SLAVES-1:0]    s_sel,
  output logic                     s_rw,
  output logic [11:0]              s_addr,
  output logic [1:0]               s_byte_enable,
  output logic [15:0]              s_wdata,
  input  logic [16*NUM_SLAVES-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES-1:0]    s_irq
);

`ifdef IO_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam logic [15:0] ACC_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  seq_state_e  state;
  logic [3:0]  req_win;
  logic [15:0] acc_cnt;
  logic        slave_hit;
  logic        local_hit;
  logic        sel_ready;
  logic        timeout_hit;
  logic        local_wr;
  logic [15:0] sel_rdata;
  logic [15:0] local_rdata;
  logic [15:0] pending;
  logic [15:0] mask;
  logic [15:0] timeout_count;

  assign req_win   = io_address[15:12];
  assign slave_hit = int'(req_win) < NUM_SLAVES;
  assign local_hit = req_win == LOCAL_WIN;
  assign local_wr  = (state == IDLE) && io_bus_enable && local_hit && !io_rw;

  // s_sel is one-hot in ACCESS, so masking with it ignores unselected slaves.
  assign sel_ready   = |(s_ready & s_sel);
  assign timeout_hit = TIMEOUT_EN && (state == ACCESS) && !sel_ready && (acc_cnt == ACC_LIMIT);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (s_sel[i]) sel_rdata = sel_rdata | s_rdata[16*i +: 16];
  end

  always_comb begin
    case (io_address[11:0])
      REG_IRQ_PENDING:   local_rdata = pending;
      REG_IRQ_MASK:      local_rdata = mask;
      REG_TIMEOUT_COUNT: local_rdata = timeout_count;
      default:           local_rdata = '0;
    endcase
  end

  io_seq_irq_ctrl #(
    .NUM_SLAVES(NUM_SLAVES)
  ) u_irq_ctrl (
    .clk          (clk),
    .reset        (reset),
    .s_irq        (s_irq),
    .timeout_evt  (timeout_hit),
    .wr_en        (local_wr),
    .wr_offset    (io_address[11:0]),
    .wr_be        (io_byte_enable),
    .wr_data      (io_write_data),
    .pending      (pending),
    .mask         (mask),
    .timeout_count(timeout_count),
    .io_irq       (io_irq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      s_sel          <= '0;
      io_acknowledge <= 1'b0;
      io_read_data   <= '0;
      s_rw           <= 1'b0;
      s_addr         <= '0;
      s_byte_enable  <= '0;
      s_wdata        <= '0;
      acc_cnt        <= '0;
    end else begin
      io_acknowledge <= 1'b0;
      case (state)
        IDLE: begin
          acc_cnt <= '0;
          if (io_bus_enable) begin
            s_rw          <= io_rw;
            s_addr        <= io_address[11:0];
            s_byte_enable <= io_byte_enable;
            s_wdata       <= io_write_data;
            if (slave_hit) begin
              for (int i = 0; i < NUM_SLAVES; i++)
                s_sel[i] <= (4'(i) == req_win);
              state <= ACCESS;
            end else begin
              io_acknowledge <= 1'b1;
              io_read_data   <= local_hit ? local_rdata : BAD_DATA;
              state          <= ACK;
            end
          end
        end
        ACCESS: begin
          if (sel_ready || timeout_hit) begin
            io_read_data   <= sel_ready ? sel_rdata : BAD_DATA;
            io_acknowledge <= 1'b1;
            s_sel          <= '0;
            state          <= ACK;
          end else if (acc_cnt != ACC_LIMIT) begin
            acc_cnt <= acc_cnt + 16'd1;
          end
        end
        ACK: begin
          io_read_data <= '0;
          state        <= HOLD;
        end
        HOLD: begin
          if (!io_bus_enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Scoreboard bench for io_bus_sequencer: stimulus pushes expected reads, a monitor pops on ack.
// Compile with IO_SEQ_TIMEOUT_EN to add the hung-slave timeout scenario.
module tb_io_bus_sequencer;

  localparam int NS = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            io_bus_enable = 1'b0;
  logic            io_rw = 1'b0;
  logic [15:0]     io_address = '0;
  logic [1:0]      io_byte_enable = '0;
  logic [15:0]     io_write_data = '0;
  logic [15:0]     io_read_data;
  logic            io_acknowledge;
  logic            io_irq;
  logic [NS-1:0]   s_sel;
  logic            s_rw;
  logic [11:0]     s_addr;
  logic [1:0]      s_byte_enable;
  logic [15:0]     s_wdata;
  logic [16*NS-1:0] s_rdata = '0;
  logic [NS-1:0]   s_ready = '0;
  logic [NS-1:0]   s_irq = '0;

  always #5 clk = ~clk;

  io_bus_sequencer #(
    .NUM_SLAVES    (NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_bus_enable (io_bus_enable),
    .io_rw         (io_rw),
    .io_address    (io_address),
    .io_byte_enable(io_byte_enable),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .io_acknowledge(io_acknowledge),
    .io_irq        (io_irq),
    .s_sel         (s_sel),
    .s_rw          (s_rw),
    .s_addr        (s_addr),
    .s_byte_enable (s_byte_enable),
    .s_wdata       (s_wdata),
    .s_rdata       (s_rdata),
    .s_ready       (s_ready),
    .s_irq         (s_irq)
  );

  typedef struct {
    logic        is_read;
    logic [15:0] data;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;

  // Behavioural view of the local register window.
  logic [15:0] m_mask = '0;
  logic [15:0] m_pending = '0;
  logic [15:0] m_count = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  function automatic logic [15:0] lane(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [15:0] local_read(input logic [11:0] off);
    case (off)
      12'h000: return m_pending;
      12'h002: return m_mask;
      12'h004: return m_count;
      default: return 16'h0000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && io_acknowledge) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_ack", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_read)
          checkOutput($sformatf("read_data@%h", mon_e.addr), io_read_data, mon_e.data);
      end
    end
  end

  // delay < 0 means the selected slave never answers.
  task automatic applyStimulus(input logic rw, input logic [15:0] addr, input logic [1:0] be,
                               input logic [15:0] wdata, input int delay, input logic [15:0] rdata);
    int          w, cyc, ready_cyc, exp_lat;
    logic        slave, acked;
    logic [15:0] exp_data;
    exp_t        e;
    w = int'(addr[15:12]);
    slave = w < NS;
    ready_cyc = (delay < 0) ? 0 : delay + 1;
    if (slave) exp_data = (delay < 0) ? 16'hDEAD : rdata;
    else if (w == 15) exp_data = local_read(addr[11:0]);
    else exp_data = 16'hDEAD;
    exp_lat = !slave ? 1 : ((delay < 0) ? TO + 1 : delay + 2);
    if (w == 15 && !rw) begin
      if (addr[11:0] == 12'h002) m_mask = (m_mask & ~lane(be)) | (wdata & lane(be));
      if (addr[11:0] == 12'h000) m_pending = (m_pending & ~(wdata & lane(be))) | 16'(s_irq);
    end
    if (slave && delay < 0) begin
      m_pending[15] = 1'b1;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end

    @(posedge clk); #1;
    io_bus_enable = 1'b1; io_rw = rw; io_address = addr;
    io_byte_enable = be; io_write_data = wdata;
    e.is_read = rw; e.data = exp_data; e.addr = addr;
    exp_q.push_back(e);
    cyc = 0;
    acked = 1'b0;
    while (!acked && cyc < exp_lat + 20) begin
      @(posedge clk); #1;
      cyc++;
      s_ready = NS'($urandom);
      s_rdata = {$urandom, $urandom};
      if (slave) begin
        s_ready[w] = (cyc == ready_cyc);
        if (cyc == ready_cyc) s_rdata[16*w +: 16] = rdata;
      end
      if (cyc == 1) begin
        checkOutput("s_sel_cycle1", 32'(s_sel), slave ? (1 << w) : 0);
        if (slave)
          checkOutput("s_fields", {s_rw, s_byte_enable, s_addr, s_wdata}, {rw, be, addr[11:0], wdata});
      end
      if (io_acknowledge) acked = 1'b1;
    end
    s_ready = '0;
    if (!acked) begin
      checkOutput("ack_seen", 0, 1);
      void'(exp_q.pop_back());
    end else begin
      checkOutput("ack_latency", cyc, exp_lat);
      checkOutput("s_sel_in_ack", 32'(s_sel), 0);
    end
    repeat (3) @(posedge clk);
    #1 io_bus_enable = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          kind, dly;
    logic        rw;
    logic [1:0]  be;
    logic [15:0] wd, rd, addr;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ack", io_acknowledge, 0);
    checkOutput("reset_sel", 32'(s_sel), 0);
    checkOutput("reset_rdata", io_read_data, 0);
    checkOutput("reset_irq", io_irq, 0);
    checkOutput("reset_fields", {s_rw, s_byte_enable, s_addr, s_wdata}, 0);
    reset = 1'b0;

    $display("[TB] slave read with 3-cycle ready delay");
    applyStimulus(1'b1, 16'h1010, 2'b11, 16'h0000, 3, 16'h1234);

    $display("[TB] byte-lane write then read of IRQ_MASK");
    applyStimulus(1'b0, 16'hF002, 2'b01, 16'hA5A5, 0, 16'h0);
    applyStimulus(1'b1, 16'hF002, 2'b11, 16'h0000, 0, 16'h0);

    $display("[TB] unmapped window read");
    applyStimulus(1'b1, 16'h7000, 2'b11, 16'h0000, 0, 16'h0);

    $display("[TB] interrupt path");
    applyStimulus(1'b0, 16'hF002, 2'b11, 16'h0004, 0, 16'h0);
    @(posedge clk); #1;
    s_irq = 4'b0100;
    m_pending[2] = 1'b1;
    @(posedge clk); #1;
    checkOutput("irq_after_1", io_irq, 0);
    @(posedge clk); #1;
    checkOutput("irq_after_2", io_irq, 1);
    applyStimulus(1'b0, 16'hF000, 2'b11, 16'h0004, 0, 16'h0);
    applyStimulus(1'b1, 16'hF000, 2'b11, 16'h0000, 0, 16'h0);
    checkOutput("irq_held", io_irq, 1);
    s_irq = '0;
    applyStimulus(1'b0, 16'hF000, 2'b11, 16'h0004, 0, 16'h0);
    applyStimulus(1'b1, 16'hF000, 2'b11, 16'h0000, 0, 16'h0);
    checkOutput("irq_cleared", io_irq, 0);

    $display("[TB] ready on the timeout-limit cycle");
    applyStimulus(1'b1, 16'h2ABC, 2'b11, 16'h0000, TO - 1, 16'hBEEF);

`ifdef IO_SEQ_TIMEOUT_EN
    $display("[TB] hung slave timeout");
    applyStimulus(1'b1, 16'h0100, 2'b11, 16'h0000, -1, 16'h0);
`endif
    applyStimulus(1'b1, 16'hF004, 2'b11, 16'h0000, 0, 16'h0);
    applyStimulus(1'b1, 16'hF000, 2'b11, 16'h0000, 0, 16'h0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      rw   = 1'($urandom_range(0, 1));
      be   = 2'($urandom_range(0, 3));
      wd   = 16'($urandom);
      rd   = 16'($urandom);
      dly  = $urandom_range(0, 4);
      case (kind)
        0, 1, 2, 3: addr = {4'(kind), 12'($urandom)};
        4:          addr = {4'hF, 12'(2 * $urandom_range(0, 4))};
        default:    addr = {4'($urandom_range(4, 14)), 12'($urandom)};
      endcase
      applyStimulus(rw, addr, be, wd, dly, rd);
    end

    $display("[TB] reset during ACCESS");
    @(posedge clk); #1;
    io_bus_enable = 1'b1; io_rw = 1'b1; io_address = 16'h3020;
    io_byte_enable = 2'b11; io_write_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sel_before_reset", 32'(s_sel), 32'h8);
    reset = 1'b1;
    io_bus_enable = 1'b0;
    @(posedge clk); #1;
    checkOutput("sel_after_reset", 32'(s_sel), 0);
    checkOutput("ack_after_reset", io_acknowledge, 0);
    reset = 1'b0;
    m_mask = '0;
    m_pending = '0;
    m_count = '0;
    repeat (3) @(posedge clk);
    applyStimulus(1'b1, 16'hF002, 2'b11, 16'h0000, 0, 16'h0);
    applyStimulus(1'b1, 16'h3020, 2'b11, 16'h0000, 1, 16'h5A5A);

    repeat (5) @(posedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
